crack_dispatcher: RTL and testbench
===================================

# crack_dispatcher

Work dispatcher for the four parallel crackers. On `start` it partitions the keyspace `0..key_limit` into fixed-size chunks and hands them to idle crackers with a round-robin request/grant handshake. It also monitors the crackers' `found` lines and halts the whole search on the first hit, latching which cracker won and the winning key. It sits between the top-level control and the cracker array, driving the crackers on one side and collecting their results on the other.

## Interface
- `KEY_W`, 32: key/candidate width.
- `CHUNK_LOG`, 8: chunk size is 2^CHUNK_LOG keys.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a search; sampled only in IDLE, FOUND or EXHAUSTED.
- `key_limit` in KEY_W: last key to try, inclusive; sampled with `start`.
- `req` in 4: level per cracker, high while that cracker is idle and wants a chunk.
- `grant` out 4: registered one-hot, one-cycle pulse; `chunk_base`/`chunk_len` are valid while any bit is high.
- `chunk_base` out KEY_W: first key of the granted chunk.
- `chunk_len` out KEY_W+1: number of keys in the chunk, 1..2^CHUNK_LOG.
- `found` in 4: cracker i hit the target; qualified by `found_key`.
- `found_key` in 4*KEY_W: cracker i key in bits [i*KEY_W +: KEY_W].
- `stop` out 1: abort all crackers; high in FOUND.
- `done` out 1: high in FOUND or EXHAUSTED.
- `success` out 1: high in FOUND only.
- `winner` out 2: index of the winning cracker.
- `win_key` out KEY_W: latched winning key.
- `elapsed` out 32: search cycle count (see Configuration).

## Operation
- States: IDLE, DISPATCH, FOUND, EXHAUSTED.
- IDLE -> DISPATCH on `start`:
  - `next_base` <= 0 (KEY_W+1 bits, overflow-safe).
  - Latch `key_limit`.
  - Clear `active[3:0]`.
- DISPATCH arbitration:
  - `eligible = req & ~grant & {4{keys_left}}`, where `keys_left = next_base <= limit`.
  - Round-robin search starts at `rr_ptr+1`; reset value of `rr_ptr` = 3, so cracker 0 is granted first.
  - At most one grant per cycle.
  - On a grant: `active[i]` <= 1, `rr_ptr` <= i, `chunk_base` <= `next_base`, `chunk_len` <= min(2^CHUNK_LOG, limit - next_base + 1), `next_base` += 2^CHUNK_LOG.
- Cracker rule: a cracker drops `req` in the cycle after it sees its `grant`. The arbiter masks a cracker's `req` during its own grant cycle.
- Found detection:
  - Qualified found: `found[i] & active[i] & ~grant[i]`.
  - Any qualified found in DISPATCH -> FOUND. Fixed priority picks the lowest index, cracker 0 first.
  - On entry to FOUND: latch `winner` and `win_key`; no grant is issued that cycle.
- DISPATCH -> EXHAUSTED when `!keys_left` and every active cracker has `req` high and is not in its grant cycle.
  - Found takes priority over exhaustion in the same cycle.
  - `key_limit = 2^KEY_W-1` must exhaust correctly; no wrap of `next_base`.
- FOUND/EXHAUSTED -> DISPATCH on `start`; this re-initialises as from IDLE and clears `success`, `stop` and `done`.
- Ignored inputs:
  - `found` in IDLE, FOUND or EXHAUSTED.
  - `found` from inactive crackers.
  - `start` while in DISPATCH.

## Timing
- Reset (any state, including mid-search): state IDLE, `rr_ptr`=3, `active`=0.
  - All outputs 0: `grant`, `chunk_base`, `chunk_len`, `stop`, `done`, `success`, `winner`, `win_key`, `elapsed`.
- `start` at edge N -> DISPATCH at N+1. The first possible `grant` is visible after edge N+2.
- `req` sampled at edge M -> `grant` high for the cycle after M. Sustained rate is one grant per cycle across crackers.
- `found` sampled at edge F:
  - `stop`, `done`, `success`, `winner`, `win_key` valid after F. `stop` stays high until `start` or `reset`.
- Exhaustion condition true at edge E -> `done`=1, `success`=0 after E.
- Outputs hold their latched values in FOUND/EXHAUSTED; `grant` stays 0 there.

## Configuration
- `CRACK_DISPATCH_ELAPSED_EN` defined:
  - 32-bit counter cleared on the DISPATCH entry edge, +1 every cycle in DISPATCH, saturating at 2^32-1.
  - Frozen in FOUND/EXHAUSTED; presented on `elapsed`.
- Not defined: counter omitted; `elapsed` tied to 0.

## Test plan
- Full exhaustion: `key_limit`=999, all `req`=1, no `found` -> grants to crackers 0,1,2,3 with bases 0,256,512,768 and lengths 256,256,256,232. After all four raise `req` again -> `done`=1, `success`=0.
- Found mid-search: cracker 2 asserts `found` with key 600 while active -> next cycle `stop`=1, `success`=1, `winner`=2, `win_key`=600. No further `grant`.
- Simultaneous found: crackers 1 and 3 found in the same cycle, keys 300 and 800 -> `winner`=1, `win_key`=300.
- Round-robin fairness: crackers 0 and 1 hold `req` continuously while 2 and 3 are busy -> grants alternate 0,1,0,1; base increments by 256 each grant.
- Edge keyspace: `key_limit`=0 -> exactly one grant, base 0, length 1, then EXHAUSTED. `key_limit`=2^32-1 with `CHUNK_LOG`=31 -> two grants, then EXHAUSTED with no wrap.
- Reset mid-search: `reset` asserted in DISPATCH after 3 grants -> next cycle all outputs 0 and state IDLE. A subsequent `start` grants base 0 to cracker 0.

Source files
------------

// File: rtl/crack_dispatcher.sv
// Keyspace dispatcher for four crackers: round-robin chunk grants, first-hit capture, exhaustion detect.
// Optional search cycle counter on `elapsed` is enabled by defining CRACK_DISPATCH_ELAPSED_EN.
module crack_dispatcher #(
  parameter int KEY_W     = 32,
  parameter int CHUNK_LOG = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_W-1:0]   key_limit,
  input  logic [3:0]         req,
  output logic [3:0]         grant,
  output logic [KEY_W-1:0]   chunk_base,
  output logic [KEY_W:0]     chunk_len,
  input  logic [3:0]         found,
  input  logic [4*KEY_W-1:0] found_key,
  output logic               stop,
  output logic               done,
  output logic               success,
  output logic [1:0]         winner,
  output logic [KEY_W-1:0]   win_key,
  output logic [31:0]        elapsed
);

  typedef enum logic [1:0] {IDLE, DISPATCH, FOUND, EXHAUSTED} state_t;

  localparam logic [KEY_W:0] CHUNK_SIZE = (KEY_W+1)'(1) << CHUNK_LOG;
  localparam logic [KEY_W:0] ONE        = (KEY_W+1)'(1);

  state_t             state, state_nxt;
  logic [KEY_W:0]     next_base;
  logic [KEY_W-1:0]   limit;
  logic [3:0]         active;
  logic [1:0]         rr_ptr;

  logic               keys_left;
  logic [3:0]         eligible;
  logic [3:0]         qual_found;
  logic               any_found;
  logic               exhaust_ok;
  logic               grant_hit;
  logic [1:0]         grant_idx;
  logic [1:0]         idx;
  logic [1:0]         win_idx;
  logic [KEY_W-1:0]   win_key_nxt;
  logic [KEY_W:0]     remaining;
  logic               do_grant;
  logic               restart;

  // next_base carries one extra bit so the final chunk can step past 2^KEY_W-1 without wrapping.
  assign keys_left  = next_base <= {1'b0, limit};
  assign eligible   = req & ~grant & {4{keys_left}};
  assign qual_found = found & active & ~grant;
  assign any_found  = |qual_found;
  assign exhaust_ok = &(~active | (req & ~grant));
  assign remaining  = {1'b0, limit} - next_base + ONE;
  assign restart    = (state != DISPATCH) && start;
  assign do_grant   = (state == DISPATCH) && grant_hit && !any_found;

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!grant_hit && eligible[idx]) begin
        grant_hit = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Scan downward so the lowest-index hit is the one left standing.
  always_comb begin
    win_idx     = 2'd0;
    win_key_nxt = '0;
    for (int k = 3; k >= 0; k--) begin
      if (qual_found[k]) begin
        win_idx     = 2'(k);
        win_key_nxt = found_key[k*KEY_W +: KEY_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = DISPATCH;
      DISPATCH: begin
        if (any_found)                    state_nxt = FOUND;
        else if (!keys_left && exhaust_ok) state_nxt = EXHAUSTED;
      end
      FOUND:     if (start) state_nxt = DISPATCH;
      EXHAUSTED: if (start) state_nxt = DISPATCH;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stop    = 1'b0;
    done    = 1'b0;
    success = 1'b0;
    case (state)
      FOUND: begin
        stop    = 1'b1;
        done    = 1'b1;
        success = 1'b1;
      end
      EXHAUSTED: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_base  <= '0;
      limit      <= '0;
      active     <= '0;
      rr_ptr     <= 2'd3;
      grant      <= '0;
      chunk_base <= '0;
      chunk_len  <= '0;
      winner     <= '0;
      win_key    <= '0;
    end else begin
      grant <= '0;
      if (restart) begin
        next_base <= '0;
        limit     <= key_limit;
        active    <= '0;
      end
      if (do_grant) begin
        grant             <= 4'b0001 << grant_idx;
        active[grant_idx] <= 1'b1;
        rr_ptr            <= grant_idx;
        chunk_base        <= next_base[KEY_W-1:0];
        chunk_len         <= (remaining > CHUNK_SIZE) ? CHUNK_SIZE : remaining;
        next_base         <= next_base + CHUNK_SIZE;
      end
      if ((state == DISPATCH) && any_found) begin
        winner  <= win_idx;
        win_key <= win_key_nxt;
      end
    end
  end

`ifdef CRACK_DISPATCH_ELAPSED_EN
  logic [31:0] elapsed_q;

  always_ff @(posedge clk) begin
    if (reset)                                         elapsed_q <= '0;
    else if (restart)                                  elapsed_q <= '0;
    else if ((state == DISPATCH) && (elapsed_q != '1)) elapsed_q <= elapsed_q + 32'd1;
  end

  assign elapsed = elapsed_q;
`else
  assign elapsed = '0;
`endif

endmodule

// File: tb/tb_crack_dispatcher.sv
// Directed self-checking bench for crack_dispatcher: exhaustion, found capture, round-robin, edge keyspaces, reset.
module tb_crack_dispatcher;

  localparam int KEY_W = 32;

  logic               clk;
  logic               reset;
  logic               start;
  logic [KEY_W-1:0]   key_limit;
  logic [3:0]         req;
  logic [3:0]         grant;
  logic [KEY_W-1:0]   chunk_base;
  logic [KEY_W:0]     chunk_len;
  logic [3:0]         found;
  logic [4*KEY_W-1:0] found_key;
  logic               stop, done, success;
  logic [1:0]         winner;
  logic [KEY_W-1:0]   win_key;
  logic [31:0]        elapsed;

  logic               start31;
  logic [KEY_W-1:0]   key_limit31;
  logic [3:0]         req31;
  logic [3:0]         grant31;
  logic [KEY_W-1:0]   chunk_base31;
  logic [KEY_W:0]     chunk_len31;
  logic [3:0]         found31;
  logic [4*KEY_W-1:0] found_key31;
  logic               stop31, done31, success31;
  logic [1:0]         winner31;
  logic [KEY_W-1:0]   win_key31;
  logic [31:0]        elapsed31;

  int compared   = 0;
  int mismatched = 0;

  crack_dispatcher #(.KEY_W(KEY_W), .CHUNK_LOG(8)) dut (
    .clk(clk), .reset(reset), .start(start), .key_limit(key_limit),
    .req(req), .grant(grant), .chunk_base(chunk_base), .chunk_len(chunk_len),
    .found(found), .found_key(found_key), .stop(stop), .done(done),
    .success(success), .winner(winner), .win_key(win_key), .elapsed(elapsed)
  );

  crack_dispatcher #(.KEY_W(KEY_W), .CHUNK_LOG(31)) dut31 (
    .clk(clk), .reset(reset), .start(start31), .key_limit(key_limit31),
    .req(req31), .grant(grant31), .chunk_base(chunk_base31), .chunk_len(chunk_len31),
    .found(found31), .found_key(found_key31), .stop(stop31), .done(done31),
    .success(success31), .winner(winner31), .win_key(win_key31), .elapsed(elapsed31)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the main DUT's control inputs, then advance one rising edge and settle.
  task automatic applyStimulus(input logic s, input logic [3:0] r, input logic [3:0] f);
    start = s;
    req   = r;
    found = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    reset = 1'b0;
  endtask

  task automatic checkGrant(input string tag, input logic [3:0] g, input logic [31:0] base, input logic [32:0] len);
    checkOutput({tag, "_grant"}, 64'(grant), 64'(g));
    checkOutput({tag, "_base"}, 64'(chunk_base), 64'(base));
    checkOutput({tag, "_len"}, 64'(chunk_len), 64'(len));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; key_limit = '0; req = '0; found = '0; found_key = '0;
    start31 = 1'b0; key_limit31 = '0; req31 = '0; found31 = '0; found_key31 = '0;

    // Reset values
    doReset();
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_base", 64'(chunk_base), 64'd0);
    checkOutput("rst_len", 64'(chunk_len), 64'd0);
    checkOutput("rst_flags", {61'd0, stop, done, success}, 64'd0);
    checkOutput("rst_winner", 64'(winner), 64'd0);
    checkOutput("rst_winkey", 64'(win_key), 64'd0);
    checkOutput("rst_elapsed", 64'(elapsed), 64'd0);

    // Full exhaustion over 0..999
    key_limit = 32'd999;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkGrant("exh_g0", 4'b0001, 32'd0, 33'd256);
    applyStimulus(1'b0, 4'b1110, 4'b0000);
    checkGrant("exh_g1", 4'b0010, 32'd256, 33'd256);
    applyStimulus(1'b0, 4'b1100, 4'b0000);
    checkGrant("exh_g2", 4'b0100, 32'd512, 33'd256);
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    checkGrant("exh_g3", 4'b1000, 32'd768, 33'd232);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("exh_busy_done", 64'(done), 64'd0);
    checkOutput("exh_busy_grant", 64'(grant), 64'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkOutput("exh_flags", {61'd0, stop, done, success}, 64'b010);
    checkOutput("exh_grant", 64'(grant), 64'd0);

    // Found mid-search, with an inactive cracker's found ignored first
    doReset();
    key_limit = 32'd999;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    found_key[3*KEY_W +: KEY_W] = 32'd5;
    applyStimulus(1'b0, 4'b1110, 4'b1000);
    checkOutput("inact_found_stop", 64'(stop), 64'd0);
    checkGrant("fnd_g1", 4'b0010, 32'd256, 33'd256);
    applyStimulus(1'b0, 4'b1100, 4'b0000);
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    checkGrant("fnd_g3", 4'b1000, 32'd768, 33'd232);
    found_key[2*KEY_W +: KEY_W] = 32'd600;
    applyStimulus(1'b0, 4'b0000, 4'b0100);
    checkOutput("fnd_flags", {61'd0, stop, done, success}, 64'b111);
    checkOutput("fnd_winner", 64'(winner), 64'd2);
    checkOutput("fnd_winkey", 64'(win_key), 64'd600);
    checkOutput("fnd_grant", 64'(grant), 64'd0);
    found_key[0 +: KEY_W] = 32'd7;
    applyStimulus(1'b0, 4'b1111, 4'b0001);
    checkOutput("fnd_hold_grant", 64'(grant), 64'd0);
    checkOutput("fnd_hold_stop", 64'(stop), 64'd1);
    checkOutput("fnd_hold_winner", 64'(winner), 64'd2);
    checkOutput("fnd_hold_winkey", 64'(win_key), 64'd600);

    // Simultaneous found from 1 and 3; found also beats exhaustion in the same cycle
    doReset();
    key_limit = 32'd999;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b1110, 4'b0000);
    applyStimulus(1'b0, 4'b1100, 4'b0000);
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    found_key[1*KEY_W +: KEY_W] = 32'd300;
    found_key[3*KEY_W +: KEY_W] = 32'd800;
    applyStimulus(1'b0, 4'b1111, 4'b1010);
    checkOutput("sim_success", 64'(success), 64'd1);
    checkOutput("sim_winner", 64'(winner), 64'd1);
    checkOutput("sim_winkey", 64'(win_key), 64'd300);

    // Restart from FOUND, then reset after three grants
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("restart_flags", {61'd0, stop, done, success}, 64'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkGrant("rs_g0", 4'b0001, 32'd0, 33'd256);
    applyStimulus(1'b0, 4'b1110, 4'b0000);
    applyStimulus(1'b0, 4'b1100, 4'b0000);
    checkGrant("rs_g2", 4'b0100, 32'd512, 33'd256);
    reset = 1'b1;
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    reset = 1'b0;
    checkOutput("mid_rst_grant", 64'(grant), 64'd0);
    checkOutput("mid_rst_base", 64'(chunk_base), 64'd0);
    checkOutput("mid_rst_len", 64'(chunk_len), 64'd0);
    checkOutput("mid_rst_flags", {61'd0, stop, done, success}, 64'd0);
    checkOutput("mid_rst_winner", 64'(winner), 64'd0);
    checkOutput("mid_rst_winkey", 64'(win_key), 64'd0);
    checkOutput("mid_rst_elapsed", 64'(elapsed), 64'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkOutput("idle_no_grant", 64'(grant), 64'd0);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkGrant("post_rst_g0", 4'b0001, 32'd0, 33'd256);

    // Round-robin between 0 and 1; start while dispatching is ignored
    doReset();
    key_limit = 32'd999;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkGrant("rr_g0", 4'b0001, 32'd0, 33'd256);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkGrant("rr_g1", 4'b0010, 32'd256, 33'd256);
    key_limit = 32'd0;
    applyStimulus(1'b1, 4'b0011, 4'b0000);
    checkGrant("rr_g2", 4'b0001, 32'd512, 33'd256);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkGrant("rr_g3", 4'b0010, 32'd768, 33'd232);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkOutput("rr_ingrant_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkOutput("rr_exh_done", 64'(done), 64'd1);

    // key_limit = 0: single one-key chunk then exhaustion
    key_limit = 32'd0;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("lim0_restart_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0000);
    checkGrant("lim0_g0", 4'b0001, 32'd0, 33'd1);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("lim0_no_grant", 64'(grant), 64'd0);
    checkOutput("lim0_busy_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0000);
    checkOutput("lim0_flags", {61'd0, stop, done, success}, 64'b010);
    checkOutput("lim0_grant", 64'(grant), 64'd0);

    // Full 32-bit keyspace with 2^31-key chunks: two grants, no wrap
    doReset();
    key_limit31 = 32'hFFFF_FFFF;
    start31 = 1'b1; req31 = 4'b0000;
    @(posedge clk); #1;
    start31 = 1'b0; req31 = 4'b1111;
    @(posedge clk); #1;
    checkOutput("big_g0_grant", 64'(grant31), 64'b0001);
    checkOutput("big_g0_base", 64'(chunk_base31), 64'd0);
    checkOutput("big_g0_len", 64'(chunk_len31), 64'h8000_0000);
    req31 = 4'b1110;
    @(posedge clk); #1;
    checkOutput("big_g1_grant", 64'(grant31), 64'b0010);
    checkOutput("big_g1_base", 64'(chunk_base31), 64'h8000_0000);
    checkOutput("big_g1_len", 64'(chunk_len31), 64'h8000_0000);
    req31 = 4'b1101;
    @(posedge clk); #1;
    checkOutput("big_nowrap_grant", 64'(grant31), 64'd0);
    checkOutput("big_busy_done", 64'(done31), 64'd0);
    req31 = 4'b1111;
    @(posedge clk); #1;
    checkOutput("big_exh_flags", {61'd0, stop31, done31, success31}, 64'b010);
    checkOutput("big_exh_grant", 64'(grant31), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
